// File: rtl/dual_read_mem_if.sv
// Request/response bundle for dual_read_mem: write/read requests in, two read ports out.
// Latency: none (signal bundle only).
// Backpressure: none here; the master must honour oBusy before issuing reads.
// Ports: validdata/iAddress/iWriteEnable/Readtoa/Readtob (master -> slave),
//        oDataA/oValidA/oDataB/oValidB/oBusy/oDropErr/oParErr (slave -> master).
interface dual_read_mem_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [DW-1:0] validdata;
  logic [AW-1:0] iAddress;
  logic          iWriteEnable;
  logic          Readtoa;
  logic          Readtob;
  logic [DW-1:0] oDataA;
  logic          oValidA;
  logic [DW-1:0] oDataB;
  logic          oValidB;
  logic          oBusy;
  logic          oDropErr;
  logic          oParErr;

  modport master (
    output validdata, iAddress, iWriteEnable, Readtoa, Readtob,
    input  oDataA, oValidA, oDataB, oValidB, oBusy, oDropErr, oParErr
  );

  modport slave (
    input  validdata, iAddress, iWriteEnable, Readtoa, Readtob,
    output oDataA, oValidA, oDataB, oValidB, oBusy, oDropErr, oParErr
  );
endinterface

// File: rtl/dual_read_mem.sv
// 2**AW x DW single-array memory, one access per cycle, reads steered to port A or B.
// Latency: granted read data and its valid pulse appear 1 cycle after the request is sampled.
// Backpressure: one pending slot per read port; oBusy while any slot is full, overflowing requests dropped (sticky oDropErr).
// Ports: clk, reset_n (async active-low), bus (dual_read_mem_if.slave).
// Optional build macro PARITY_EN: array stores an even-parity bit, oParErr pulses on a bad read.
module dual_read_mem #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  dual_read_mem_if.slave   bus
);

`ifdef PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  logic [MW-1:0] mem [2**AW];

  logic          pend_a, pend_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          pend_a_nxt, pend_b_nxt;
  logic [AW-1:0] addr_a_nxt, addr_b_nxt;
  logic          drop_err, drop_nxt;
  logic          busy;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b;

  // The generator leaves requests X early on; only a clean 1 counts as a request.
  logic wr_req, rd_req_a, rd_req_b;
  assign wr_req   = (bus.iWriteEnable === 1'b1);
  assign rd_req_a = (bus.Readtoa === 1'b1);
  assign rd_req_b = (bus.Readtob === 1'b1);

  // Fixed priority: write > pendA > pendB > newA > newB.
  logic g_pa, g_pb, g_na, g_nb;
  assign g_pa = !wr_req && pend_a;
  assign g_pb = !wr_req && !pend_a && pend_b;
  assign g_na = !wr_req && !pend_a && !pend_b && rd_req_a;
  assign g_nb = !wr_req && !pend_a && !pend_b && !rd_req_a && rd_req_b;

  logic gnt_a, gnt_b;
  assign gnt_a = g_pa || g_na;
  assign gnt_b = g_pb || g_nb;

  logic [AW-1:0] rd_addr;
  assign rd_addr = g_pa ? addr_a : (g_pb ? addr_b : bus.iAddress);

  logic [MW-1:0] rd_word, wr_word;
  assign rd_word = mem[rd_addr];
`ifdef PARITY_EN
  // Even parity: the stored word XORs to 0 when intact.
  assign wr_word = {^bus.validdata, bus.validdata};
`else
  assign wr_word = bus.validdata;
`endif

  // Array is not reset; it is written at the edge so a read on the next cycle sees new data.
  always_ff @(posedge clk) begin
    if (wr_req) mem[bus.iAddress] <= wr_word;
  end

  // Slot update. A slot being granted this cycle is free to take a new request.
  always_comb begin
    pend_a_nxt = pend_a;
    addr_a_nxt = addr_a;
    pend_b_nxt = pend_b;
    addr_b_nxt = addr_b;
    drop_nxt   = drop_err;
    if (g_pa) pend_a_nxt = 1'b0;
    if (g_pb) pend_b_nxt = 1'b0;
    if (rd_req_a && !g_na) begin
      if (!pend_a || g_pa) begin
        pend_a_nxt = 1'b1;
        addr_a_nxt = bus.iAddress;
      end else begin
        drop_nxt = 1'b1;
      end
    end
    if (rd_req_b && !g_nb) begin
      if (!pend_b || g_pb) begin
        pend_b_nxt = 1'b1;
        addr_b_nxt = bus.iAddress;
      end else begin
        drop_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      drop_err <= 1'b0;
      busy     <= 1'b0;
      data_a   <= '0;
      data_b   <= '0;
      valid_a  <= 1'b0;
      valid_b  <= 1'b0;
    end else begin
      pend_a   <= pend_a_nxt;
      pend_b   <= pend_b_nxt;
      addr_a   <= addr_a_nxt;
      addr_b   <= addr_b_nxt;
      drop_err <= drop_nxt;
      busy     <= pend_a_nxt || pend_b_nxt;
      valid_a  <= gnt_a;
      valid_b  <= gnt_b;
      if (gnt_a) data_a <= rd_word[DW-1:0];
      if (gnt_b) data_b <= rd_word[DW-1:0];
    end
  end

`ifdef PARITY_EN
  logic par_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_err <= 1'b0;
    else          par_err <= (gnt_a || gnt_b) && (^rd_word);
  end
  assign bus.oParErr = par_err;
`else
  assign bus.oParErr = 1'b0;
`endif

  assign bus.oDataA   = data_a;
  assign bus.oValidA  = valid_a;
  assign bus.oDataB   = data_b;
  assign bus.oValidB  = valid_b;
  assign bus.oBusy    = busy;
  assign bus.oDropErr = drop_err;

endmodule

// File: tb/tb_dual_read_mem.sv
// Directed bench for dual_read_mem: reset, port A/B reads, collisions, drops, mid-op reset.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_dual_read_mem;
  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  dual_read_mem_if #(.AW(10), .DW(8)) bus ();

  dual_read_mem #(.AW(10), .DW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply one request set, let one edge sample it, return just after that edge.
  task automatic drive(input logic we, input logic ra, input logic rb,
                       input logic [9:0] addr, input logic [7:0] data);
    bus.iWriteEnable = we;
    bus.Readtoa      = ra;
    bus.Readtob      = rb;
    bus.iAddress     = addr;
    bus.validdata    = data;
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++; if (bus.oValidA !== 1'b0) begin bad++; $display("FAIL rst_validA got=%b exp=0", bus.oValidA); end
    total++; if (bus.oValidB !== 1'b0) begin bad++; $display("FAIL rst_validB got=%b exp=0", bus.oValidB); end
    total++; if (bus.oDataA !== 8'h00) begin bad++; $display("FAIL rst_dataA got=%h exp=00", bus.oDataA); end
    total++; if (bus.oDataB !== 8'h00) begin bad++; $display("FAIL rst_dataB got=%h exp=00", bus.oDataB); end
    total++; if ({bus.oBusy, bus.oDropErr, bus.oParErr} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {bus.oBusy, bus.oDropErr, bus.oParErr});
    end
    #10;
    bus.iWriteEnable = 1'b0; bus.Readtoa = 1'b0; bus.Readtob = 1'b0;
    bus.iAddress = '0; bus.validdata = '0;
    #4 reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_read_a();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 8'd8);
    total++; if (bus.oValidA !== 1'b0) begin bad++; $display("FAIL wr_no_validA got=%b exp=0", bus.oValidA); end
    drive(1'b0, 1'b1, 1'b0, 10'h000, 8'd0);
    total++; if (bus.oValidA !== 1'b1) begin bad++; $display("FAIL rdA_valid got=%b exp=1", bus.oValidA); end
    total++; if (bus.oDataA !== 8'd8) begin bad++; $display("FAIL rdA_data got=%0d exp=8", bus.oDataA); end
    total++; if (bus.oValidB !== 1'b0) begin bad++; $display("FAIL rdA_validB got=%b exp=0", bus.oValidB); end
    idle();
    total++; if (bus.oValidA !== 1'b0) begin bad++; $display("FAIL rdA_pulse got=%b exp=0", bus.oValidA); end
  endtask

  task automatic test_read_b();
    drive(1'b1, 1'b0, 1'b0, 10'd10, 8'd16);
    drive(1'b0, 1'b0, 1'b1, 10'd10, 8'd0);
    total++; if (bus.oValidB !== 1'b1) begin bad++; $display("FAIL rdB_valid got=%b exp=1", bus.oValidB); end
    total++; if (bus.oDataB !== 8'd16) begin bad++; $display("FAIL rdB_data got=%0d exp=16", bus.oDataB); end
    total++; if (bus.oValidA !== 1'b0) begin bad++; $display("FAIL rdB_validA got=%b exp=0", bus.oValidA); end
    idle();
  endtask

  task automatic test_two_addr();
    drive(1'b1, 1'b0, 1'b0, 10'h01F, 8'd32);
    drive(1'b1, 1'b0, 1'b0, 10'h3FF, 8'd64);
    drive(1'b0, 1'b1, 1'b0, 10'h01F, 8'd0);
    total++; if ({bus.oValidA, bus.oDataA} !== {1'b1, 8'd32}) begin
      bad++; $display("FAIL addr1F_A got=%b/%0d exp=1/32", bus.oValidA, bus.oDataA);
    end
    drive(1'b0, 1'b0, 1'b1, 10'h3FF, 8'd0);
    total++; if ({bus.oValidB, bus.oDataB} !== {1'b1, 8'd64}) begin
      bad++; $display("FAIL addr3FF_B got=%b/%0d exp=1/64", bus.oValidB, bus.oDataB);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b1, 10'h3FF, 8'd0);
    total++; if ({bus.oValidA, bus.oDataA, bus.oValidB} !== {1'b1, 8'd64, 1'b0}) begin
      bad++; $display("FAIL b2b_first got=%b/%0d/%b exp=1/64/0", bus.oValidA, bus.oDataA, bus.oValidB);
    end
    total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got=%b exp=1", bus.oBusy); end
    idle();
    total++; if ({bus.oValidB, bus.oDataB, bus.oValidA} !== {1'b1, 8'd64, 1'b0}) begin
      bad++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/64/0", bus.oValidB, bus.oDataB, bus.oValidA);
    end
    total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL b2b_busy0 got=%b exp=0", bus.oBusy); end
    idle();
    total++; if ({bus.oValidA, bus.oValidB} !== 2'b00) begin
      bad++; $display("FAIL b2b_quiet got=%b exp=00", {bus.oValidA, bus.oValidB});
    end
  endtask

  // Write+A parks A; write+B parks B; next B finds slot B full and not granted -> dropped.
  task automatic test_drop();
    drive(1'b1, 1'b1, 1'b0, 10'h055, 8'hAA);
    total++; if ({bus.oBusy, bus.oValidA} !== 2'b10) begin
      bad++; $display("FAIL drop_park got=%b exp=10", {bus.oBusy, bus.oValidA});
    end
    drive(1'b1, 1'b0, 1'b1, 10'h066, 8'hBB);
    total++; if ({bus.oValidA, bus.oValidB, bus.oDropErr} !== 3'b000) begin
      bad++; $display("FAIL drop_wr2 got=%b exp=000", {bus.oValidA, bus.oValidB, bus.oDropErr});
    end
    drive(1'b0, 1'b0, 1'b1, 10'h077, 8'h00);
    total++; if ({bus.oValidA, bus.oDataA} !== {1'b1, 8'hAA}) begin
      bad++; $display("FAIL drop_servA got=%b/%h exp=1/aa", bus.oValidA, bus.oDataA);
    end
    total++; if ({bus.oDropErr, bus.oBusy} !== 2'b11) begin
      bad++; $display("FAIL drop_err got=%b exp=11", {bus.oDropErr, bus.oBusy});
    end
    idle();
    total++; if ({bus.oValidB, bus.oDataB, bus.oBusy} !== {1'b1, 8'hBB, 1'b0}) begin
      bad++; $display("FAIL drop_servB got=%b/%h/%b exp=1/bb/0", bus.oValidB, bus.oDataB, bus.oBusy);
    end
    idle();
    total++; if ({bus.oValidB, bus.oDropErr} !== 2'b01) begin
      bad++; $display("FAIL drop_sticky got=%b exp=01", {bus.oValidB, bus.oDropErr});
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 10'h100, 8'h5A);
    total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", bus.oBusy); end
    bus.iWriteEnable = 1'b0; bus.Readtoa = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if ({bus.oBusy, bus.oDropErr, bus.oValidA, bus.oDataA} !== {3'b000, 8'h00}) begin
      bad++; $display("FAIL mid_clear got=%b/%b/%b/%h exp=0/0/0/00",
                      bus.oBusy, bus.oDropErr, bus.oValidA, bus.oDataA);
    end
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      total++; if ({bus.oValidA, bus.oValidB, bus.oBusy} !== 3'b000) begin
        bad++; $display("FAIL mid_after%0d got=%b exp=000", i, {bus.oValidA, bus.oValidB, bus.oBusy});
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 8'h07);
    drive(1'b0, 1'b1, 1'b0, 10'h000, 8'h00);
    total++; if ({bus.oValidA, bus.oParErr} !== 2'b10) begin
      bad++; $display("FAIL par_clean got=%b exp=10", {bus.oValidA, bus.oParErr});
    end
    dut.mem[0] = dut.mem[0] ^ 9'h001;
    drive(1'b0, 1'b1, 1'b0, 10'h000, 8'h00);
    total++; if ({bus.oValidA, bus.oParErr} !== 2'b11) begin
      bad++; $display("FAIL par_err got=%b exp=11", {bus.oValidA, bus.oParErr});
    end
    idle();
    total++; if (bus.oParErr !== 1'b0) begin bad++; $display("FAIL par_pulse got=%b exp=0", bus.oParErr); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_a();
    test_read_b();
    test_two_addr();
    test_back_to_back();
    test_drop();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
